// File: rtl/cfg_sink.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sink
// Description : Serial configuration sink. It assembles MSB-first 32-bit words
//               from a strobed bit stream into a DEPTH-word store, announces
//               each word with a one-cycle write strobe, and offers a pass-through
//               chain output and serial readback of the store.
//               Optional macro CFG_SINK_ADLER_EN adds a running Adler-32 over
//               the loaded bytes; without it adler_out is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_sink #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prset,
    input  logic          prog_en,
    input  logic          fpga_head,
    input  logic          rd_mode,
    output logic          fpga_tail,
    output logic          cfg_we,
    output logic [AW-1:0] cfg_addr,
    output logic [31:0]   cfg_data,
    output logic          cfg_done,
    output logic          overflow,
    output logic [31:0]   adler_out
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_DONE     = 2'd2,
        S_READBACK = 2'd3
    } state_t;

    localparam logic [4:0]    c_LAST_BIT  = 5'd31;
    localparam logic [AW-1:0] c_LAST_WORD = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [31:0]   r_shreg;
    logic [31:0]   r_rb;
    logic [4:0]    r_bitcnt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_tail;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic          r_done;
    logic          r_ovf;

    logic [31:0]   w_shreg_shift;
    logic [31:0]   w_shreg_nxt;
    logic [31:0]   w_rb_nxt;
    logic          w_tail_nxt;
    logic          w_load_stb;
    logic          w_word_end;
    logic          w_last_word;
    logic          w_rb_start;
    logic          w_rb_stb;
    logic          w_rb_word_end;
    logic          w_rb_last;
    logic [AW-1:0] w_rd_ptr_inc;

    assign w_shreg_shift = {r_shreg[30:0], fpga_head};
    assign w_load_stb    = (r_state == S_LOAD) && !prset && prog_en;
    assign w_word_end    = w_load_stb && (r_bitcnt == c_LAST_BIT);
    assign w_last_word   = w_word_end && (r_wr_ptr == c_LAST_WORD);
    assign w_rb_start    = (r_state == S_DONE) && !prset && rd_mode;
    assign w_rb_stb      = (r_state == S_READBACK) && !prset && rd_mode && prog_en;
    assign w_rb_word_end = w_rb_stb && (r_bitcnt == c_LAST_BIT);
    assign w_rb_last     = w_rb_word_end && (r_rd_ptr == c_LAST_WORD);
    assign w_rd_ptr_inc  = r_rd_ptr + AW'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; prset dominates every other input
    always_comb begin
        w_state_nxt = r_state;
        if (prset) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_LOAD;
                S_LOAD:     if (w_last_word) w_state_nxt = S_DONE;
                S_DONE:     if (rd_mode) w_state_nxt = S_READBACK;
                S_READBACK: if (!rd_mode || w_rb_last) w_state_nxt = S_DONE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of both shift registers and of the serial output
    always_comb begin
        w_shreg_nxt = r_shreg;
        w_rb_nxt    = r_rb;
        w_tail_nxt  = 1'b0;
        if (prset) begin
            w_shreg_nxt = 32'd0;
        end else if (w_load_stb) begin
            w_shreg_nxt = w_shreg_shift;
        end
        if (w_rb_start) begin
            w_rb_nxt = r_mem[0];
        end else if (w_rb_word_end) begin
            w_rb_nxt = r_mem[w_rd_ptr_inc];
        end else if (w_rb_stb) begin
            w_rb_nxt = {r_rb[30:0], 1'b0};
        end
        if (w_state_nxt == S_LOAD) begin
            w_tail_nxt = w_shreg_nxt[31];
        end else if (w_state_nxt == S_READBACK) begin
            w_tail_nxt = w_rb_nxt[31];
        end
    end

    // Shift registers and the registered chain/readback output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= 32'd0;
            r_rb    <= 32'd0;
            r_tail  <= 1'b0;
        end else begin
            r_shreg <= w_shreg_nxt;
            r_rb    <= w_rb_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Bit counter and word pointers for both loading and readback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= 5'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (prset) begin
            r_bitcnt <= 5'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_load_stb) begin
            r_bitcnt <= r_bitcnt + 5'd1;
            if (w_word_end) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
        end else if (w_rb_start) begin
            r_bitcnt <= 5'd0;
            r_rd_ptr <= '0;
        end else if (r_state == S_READBACK) begin
            if (!rd_mode) begin
                r_bitcnt <= 5'd0;
                r_rd_ptr <= '0;
            end else if (prog_en) begin
                // Both wrap to zero after the last bit of the last word
                r_bitcnt <= r_bitcnt + 5'd1;
                if (w_rb_word_end) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

    // Word-write strobe, its address/data, and the completion/overflow flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= 32'd0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (prset) begin
                r_done <= 1'b0;
            end else begin
                if (w_word_end) begin
                    r_we   <= 1'b1;
                    r_addr <= r_wr_ptr;
                    r_data <= w_shreg_shift;
                end
                if (w_last_word) begin
                    r_done <= 1'b1;
                end
                if ((r_state == S_DONE) && prog_en) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Word store; contents survive both resets
    always_ff @(posedge clk) begin
        if (w_word_end) begin
            r_mem[r_wr_ptr] <= w_shreg_shift;
        end
    end

`ifdef CFG_SINK_ADLER_EN
    logic [15:0] r_adl_a;
    logic [15:0] r_adl_b;
    logic [16:0] w_a_sum;
    logic [16:0] w_a_red;
    logic [15:0] w_a_new;
    logic [16:0] w_b_sum;
    logic [16:0] w_b_red;
    logic [15:0] w_b_new;

    // Modulo-65521 sums; each operand is already reduced so one subtraction suffices
    always_comb begin
        w_a_sum = {1'b0, r_adl_a} + {9'd0, w_shreg_shift[7:0]};
        w_a_red = w_a_sum - 17'd65521;
        w_a_new = (w_a_sum >= 17'd65521) ? w_a_red[15:0] : w_a_sum[15:0];
        w_b_sum = {1'b0, r_adl_b} + {1'b0, w_a_new};
        w_b_red = w_b_sum - 17'd65521;
        w_b_new = (w_b_sum >= 17'd65521) ? w_b_red[15:0] : w_b_sum[15:0];
    end

    // Checksum accumulators advance once per completed byte during a load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adl_a <= 16'd1;
            r_adl_b <= 16'd0;
        end else if (prset) begin
            r_adl_a <= 16'd1;
            r_adl_b <= 16'd0;
        end else if (w_load_stb && (r_bitcnt[2:0] == 3'd7)) begin
            r_adl_a <= w_a_new;
            r_adl_b <= w_b_new;
        end
    end

    assign adler_out = {r_adl_b, r_adl_a};
`else
    assign adler_out = 32'h0000_0000;
`endif

    assign fpga_tail = r_tail;
    assign cfg_we    = r_we;
    assign cfg_addr  = r_addr;
    assign cfg_data  = r_data;
    assign cfg_done  = r_done;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cfg_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_sink
// Description : Self-checking bench for cfg_sink (DEPTH=4). A bit-history
//               model predicts every output each cycle; directed literals pin
//               pulse counts, addresses, words, readback and the checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_sink;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

`ifdef CFG_SINK_ADLER_EN
    localparam logic [31:0] c_ADLER_RST  = 32'h0000_0001;
    localparam logic [31:0] c_ADLER_LOAD = 32'h4338_0849;
`else
    localparam logic [31:0] c_ADLER_RST  = 32'h0000_0000;
    localparam logic [31:0] c_ADLER_LOAD = 32'h0000_0000;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_DONE = 2;
    localparam int PH_RB   = 3;

    logic          clk;
    logic          reset;
    logic          prset;
    logic          prog_en;
    logic          fpga_head;
    logic          rd_mode;
    logic          fpga_tail;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_data;
    logic          cfg_done;
    logic          overflow;
    logic [31:0]   adler_out;

    cfg_sink #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .prset     (prset),
        .prog_en   (prog_en),
        .fpga_head (fpga_head),
        .rd_mode   (rd_mode),
        .fpga_tail (fpga_tail),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .overflow  (overflow),
        .adler_out (adler_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase;
    int          m_nstb;
    int          m_rbk;
    int          m_a;
    int          m_b;
    logic        m_hist [0:511];
    logic [31:0] m_store [0:DEPTH-1];
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [31:0] m_data;
    logic        m_done;
    logic        m_ovf;

    always @(posedge clk or negedge reset) begin
        logic [7:0]  byte_v;
        logic [31:0] word_v;
        if (!reset) begin
            m_phase = PH_IDLE; m_nstb = 0; m_rbk = 0;
            m_we = 1'b0; m_addr = '0; m_data = 32'd0;
            m_done = 1'b0; m_ovf = 1'b0; m_a = 1; m_b = 0;
        end else begin
            m_we = 1'b0;
            if (prset) begin
                m_phase = PH_IDLE; m_nstb = 0; m_rbk = 0;
                m_done = 1'b0; m_a = 1; m_b = 0;
            end else begin
                case (m_phase)
                    PH_IDLE: m_phase = PH_LOAD;
                    PH_LOAD: if (prog_en) begin
                        m_hist[m_nstb] = fpga_head;
                        m_nstb++;
                        if (m_nstb % 8 == 0) begin
                            byte_v = 8'd0;
                            for (int k = 8; k >= 1; k--) byte_v = {byte_v[6:0], m_hist[m_nstb-k]};
                            m_a = (m_a + int'(byte_v)) % 65521;
                            m_b = (m_b + m_a) % 65521;
                        end
                        if (m_nstb % 32 == 0) begin
                            word_v = 32'd0;
                            for (int k = 32; k >= 1; k--) word_v = {word_v[30:0], m_hist[m_nstb-k]};
                            m_store[m_nstb/32-1] = word_v;
                            m_we   = 1'b1;
                            m_addr = AW'(m_nstb/32-1);
                            m_data = word_v;
                            if (m_nstb == DEPTH*32) begin
                                m_phase = PH_DONE;
                                m_done  = 1'b1;
                            end
                        end
                    end
                    PH_DONE: begin
                        if (prog_en) m_ovf = 1'b1;
                        if (rd_mode) begin
                            m_phase = PH_RB;
                            m_rbk   = 0;
                        end
                    end
                    default: begin
                        if (!rd_mode) begin
                            m_phase = PH_DONE;
                        end else if (prog_en) begin
                            m_rbk++;
                            if (m_rbk == DEPTH*32) m_phase = PH_DONE;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic exp_tail();
        if (m_phase == PH_LOAD) return (m_nstb >= 32) ? m_hist[m_nstb-32] : 1'b0;
        if (m_phase == PH_RB)   return m_store[m_rbk/32][31 - (m_rbk % 32)];
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_adler();
`ifdef CFG_SINK_ADLER_EN
        return {m_b[15:0], m_a[15:0]};
`else
        return 32'h0000_0000;
`endif
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("fpga_tail", {31'd0, fpga_tail}, {31'd0, exp_tail()});
            chk("cfg_we",    {31'd0, cfg_we},    {31'd0, m_we});
            chk("cfg_addr",  {{(32-AW){1'b0}}, cfg_addr}, {{(32-AW){1'b0}}, m_addr});
            chk("cfg_data",  cfg_data,           m_data);
            chk("cfg_done",  {31'd0, cfg_done},  {31'd0, m_done});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            chk("adler_out", adler_out,          exp_adler());
        end
    end

    // Pulse capture for the directed literal checks
    int          n_we = 0;
    logic [AW-1:0] cap_addr [0:15];
    logic [31:0] cap_data [0:15];
    always @(negedge clk) begin
        if (reset && cfg_we) begin
            if (n_we < 16) begin
                cap_addr[n_we] = cfg_addr;
                cap_data[n_we] = cfg_data;
            end
            n_we++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] words [0:DEPTH-1];
    logic [31:0] rb_words [0:DEPTH-1];

    task automatic strobe(input logic b);
        prog_en   = 1'b1;
        fpga_head = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        prog_en   = 1'b0;
        fpga_head = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) strobe(w[i]);
    endtask

    task automatic do_readback();
        rd_mode = 1'b1;
        idle(1);
        for (int w = 0; w < DEPTH; w++) begin
            for (int i = 31; i >= 0; i--) begin
                rb_words[w][i] = fpga_tail;
                strobe(1'b0);
            end
        end
        rd_mode = 1'b0;
        prog_en = 1'b0;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_tail"},  {31'd0, fpga_tail}, 32'd0);
        chk({tag, "_we"},    {31'd0, cfg_we},    32'd0);
        chk({tag, "_addr"},  {{(32-AW){1'b0}}, cfg_addr}, 32'd0);
        chk({tag, "_data"},  cfg_data,           32'd0);
        chk({tag, "_done"},  {31'd0, cfg_done},  32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow},  32'd0);
        chk({tag, "_adler"}, adler_out,          c_ADLER_RST);
    endtask

    initial begin
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h1234_5678;
        words[2] = 32'h0000_0000;
        words[3] = 32'hFFFF_FFFF;

        reset = 1'b0; prset = 1'b1; prog_en = 1'b0; fpga_head = 1'b0; rd_mode = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(2);
        chk_outputs_reset("rst");

        // Full load of four words
        prset = 1'b0;
        idle(1);
        for (int w = 0; w < DEPTH; w++) send_word(words[w]);
        idle(2);
        chk("load_we_count", n_we, 32'd4);
        for (int w = 0; w < DEPTH; w++) begin
            chk("load_addr", {{(32-AW){1'b0}}, cap_addr[w]}, w);
            chk("load_data", cap_data[w], words[w]);
        end
        chk("load_done",  {31'd0, cfg_done}, 32'd1);
        chk("load_adler", adler_out, c_ADLER_LOAD);

        // Full readback
        do_readback();
        idle(2);
        for (int w = 0; w < DEPTH; w++) chk("rb1_word", rb_words[w], words[w]);
        chk("rb1_tail_after", {31'd0, fpga_tail}, 32'd0);

        // 129th strobe in DONE
        strobe(1'b1);
        idle(2);
        chk("ovf_set",      {31'd0, overflow}, 32'd1);
        chk("ovf_we_count", n_we, 32'd4);
        chk("ovf_adler",    adler_out, c_ADLER_LOAD);
        do_readback();
        idle(2);
        for (int w = 0; w < DEPTH; w++) chk("rb2_word", rb_words[w], words[w]);

        // Aborted readback
        rd_mode = 1'b1;
        idle(1);
        for (int i = 0; i < 10; i++) strobe(1'b0);
        rd_mode = 1'b0;
        idle(3);
        chk("abort_tail", {31'd0, fpga_tail}, 32'd0);
        chk("abort_done", {31'd0, cfg_done}, 32'd1);

        // Partial load interrupted by prset after 40 strobes
        prset = 1'b1;
        idle(2);
        prset = 1'b0;
        n_we  = 0;
        idle(1);
        send_word(32'hA5A5_0F0F);
        for (int i = 0; i < 8; i++) strobe(i[0]);
        prset = 1'b1;
        prog_en = 1'b0;
        idle(3);
        chk("part_we_count", n_we, 32'd1);
        chk("part_addr", {{(32-AW){1'b0}}, cap_addr[0]}, 32'd0);
        chk("part_data", cap_data[0], 32'hA5A5_0F0F);
        chk("part_tail", {31'd0, fpga_tail}, 32'd0);

        // Fresh load restarts at address 0
        prset = 1'b0;
        n_we  = 0;
        idle(1);
        send_word(32'h0F1E_2D3C);
        idle(1);
        chk("fresh_we_count", n_we, 32'd1);
        chk("fresh_addr", {{(32-AW){1'b0}}, cap_addr[0]}, 32'd0);
        chk("fresh_data", cap_data[0], 32'h0F1E_2D3C);
        send_word(32'h8765_4321);
        for (int i = 0; i < 12; i++) strobe(i[1]);

        // Asynchronous reset in the middle of a clock period
        #2;
        reset = 1'b0;
        #1;
        chk_outputs_reset("async");
        prog_en = 1'b0;
        prset   = 1'b1;
        @(posedge clk); #1;
        idle(2);
        reset = 1'b1;
        idle(3);
        chk_outputs_reset("post");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
